prbs_seq_ctrl: RTL
==================

PRBS_SEQ_CTRL -- requirements
Module: prbs_seq_ctrl

Interface
REQ-001 The block SHALL have these parameters: LEN_W, default 16, width of the payload length field; GAP_CYCLES, default 4, idle cycles between frames (>=1); DP_LAT, default 1, datapath output latency in cycles (>=0).
REQ-002 The block SHALL have these ports, one per line as: name  direction  width  meaning.
clk  in  1  single clock, all state on rising edge.
rst  in  1  asynchronous active-high reset.
cfg_valid  in  1  frame request valid.
cfg_ready  out  1  controller accepts a request this cycle.
cfg_pattern  in  32  four preamble bytes for the generator.
cfg_n  in  8  preamble repeat count.
cfg_len  in  LEN_W  PRBS payload byte count.
abort  in  1  terminate the current frame.
gen_rst  out  1  one-cycle synchronous clear pulse to the generator.
gen_enable  out  1  generator advance enable.
gen_bytes  out  32  latched cfg_pattern.
gen_n  out  8  latched cfg_n.
byte_valid  out  1  generator output byte valid.
frame_start  out  1  pulse on first byte_valid of a frame.
frame_end  out  1  pulse on last byte_valid of a frame.
busy  out  1  high in any state other than IDLE.
done  out  1  one-cycle pulse when a frame completes or aborts.
aborted  out  1  qualifies done: 1 = frame was aborted.
err  out  1  one-cycle pulse when a request is rejected.

Function
REQ-003 The block SHALL implement the states IDLE, LOAD, PRE, PAY, DRAIN and GAP.
REQ-004 cfg_ready SHALL be 1 only in IDLE; a request SHALL be accepted when cfg_valid && cfg_ready.
REQ-005 On acceptance with cfg_len == 0, the block SHALL pulse err for one cycle, SHALL stay in IDLE, and SHALL leave gen_bytes and gen_n unchanged.
REQ-006 On acceptance with cfg_len != 0, the block SHALL latch cfg_pattern into gen_bytes and cfg_n into gen_n, and SHALL enter LOAD.
REQ-007 In LOAD, gen_rst SHALL be 1 for exactly one cycle; the next state SHALL be PRE if gen_n != 0, else PAY.
REQ-008 In PRE, gen_enable SHALL be 1 for exactly 4*gen_n cycles, counted by a 10-bit counter; the block SHALL then go to PAY with no idle cycle between.
REQ-009 In PAY, gen_enable SHALL be 1 for exactly the latched cfg_len cycles, counted by an LEN_W-bit counter; the block SHALL then go to DRAIN.
REQ-010 The enable history SHALL be a DP_LAT-deep shift register fed by gen_enable.
- byte_valid SHALL equal gen_enable delayed DP_LAT cycles.
- When DP_LAT = 0, byte_valid SHALL equal gen_enable.
REQ-011 DRAIN SHALL last until the shift register is empty, and SHALL take zero cycles when DP_LAT = 0; the block SHALL then go to GAP.
REQ-012 GAP SHALL last GAP_CYCLES cycles, after which the block SHALL return to IDLE; done SHALL pulse on the IDLE entry cycle with aborted = 0.
REQ-013 frame_start SHALL coincide with the first byte_valid after LOAD; frame_end SHALL coincide with the last byte_valid; for a frame of exactly one byte, both SHALL pulse in the same cycle.
REQ-014 Total byte_valid cycles per non-aborted frame SHALL be 4*n + len.
REQ-015 abort sampled high in LOAD, PRE or PAY SHALL take effect as follows:
- gen_enable SHALL be 0 from the next cycle.
- The block SHALL enter DRAIN then GAP.
- The in-flight bytes (DP_LAT of them) SHALL still be flagged byte_valid.
- frame_end SHALL pulse on the last of these bytes, or SHALL NOT pulse if none are in flight.
- done SHALL pulse on IDLE entry with aborted = 1.
REQ-016 abort SHALL be ignored in IDLE, DRAIN and GAP; cfg_valid SHALL be ignored outside IDLE.
REQ-017 Counters SHALL NOT wrap: cfg_n = 255 SHALL give 1020 preamble cycles, and cfg_len = 2^LEN_W-1 SHALL be legal.
REQ-018 All outputs SHALL be registered, except cfg_ready and busy, which SHALL be decoded from the state register.

Reset
REQ-019 While rst = 1, asynchronously, the block SHALL hold state = IDLE, all counters at 0, the shift register at 0, gen_bytes = 0 and gen_n = 0.
REQ-020 While rst = 1, gen_rst, gen_enable, byte_valid, frame_start, frame_end, done, aborted and err SHALL all be 0.
REQ-021 Reset asserted mid-frame SHALL drop gen_enable and byte_valid immediately, and no done pulse SHALL follow.
REQ-022 After rst deasserts, cfg_ready SHALL be 1 on the first clock edge.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- pattern = 0xA1B2C3D4, n = 2, len = 5, DP_LAT = 1 -> gen_rst at cycle 1 after accept; gen_enable 13 cycles; byte_valid 13 cycles delayed by 1; frame_start/frame_end on the first/last; done after 4 GAP cycles; aborted = 0.
- n = 0, len = 1 -> LOAD then 1 PAY cycle; frame_start and frame_end in the same cycle; done with aborted = 0.
- len = 0 -> err pulse, no gen_rst, cfg_ready stays 1, gen_bytes unchanged.
- n = 3, len = 100, abort on the 5th PRE cycle -> gen_enable low the next cycle; 5 byte_valid total; frame_end on the 5th; done with aborted = 1.
- back-to-back cfg_valid held high -> second frame starts exactly GAP_CYCLES+1 cycles after the first done's preceding GAP entry, with no overlap of byte_valid.
- rst pulse during PAY -> all outputs 0 at once; busy = 0; no done; a new request is accepted normally afterward.

Source files
------------

// File: rtl/prbs_seq_ctrl.sv
// Frame sequencer for a PRBS byte generator: preamble (4*n bytes), payload (len bytes),
// pipeline drain and inter-frame gap, with abort and request rejection.
module prbs_seq_ctrl #(
   parameter int unsigned LEN_W      = 16,
   parameter int unsigned GAP_CYCLES = 4,
   parameter int unsigned DP_LAT     = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [31:0]      cfg_pattern,
   input  logic [7:0]       cfg_n,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic             abort,
   output logic             gen_rst,
   output logic             gen_enable,
   output logic [31:0]      gen_bytes,
   output logic [7:0]       gen_n,
   output logic             byte_valid,
   output logic             frame_start,
   output logic             frame_end,
   output logic             busy,
   output logic             done,
   output logic             aborted,
   output logic             err
);

   localparam int unsigned PRE_W = 10;
   localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      PRE   = 3'd2,
      PAY   = 3'd3,
      DRAIN = 3'd4,
      GAP   = 3'd5
   } state_t;

   // With no datapath latency there is nothing to drain.
   localparam state_t END_ST = (DP_LAT == 0) ? GAP : DRAIN;

   state_t             state, state_d;
   logic [PRE_W-1:0]   pre_cnt, pre_cnt_d;
   logic [LEN_W-1:0]   pay_cnt, pay_cnt_d;
   logic [GAP_W-1:0]   gap_cnt, gap_cnt_d;
   logic [LEN_W-1:0]   len_q;
   logic               abort_q, abort_d;
   logic               en_d, take, err_d, done_d;
   logic               pend, fs_d, fe_d;
   logic [PRE_W-1:0]   pre_last;
   logic [DP_LAT:0]    pipe;   // pipe[0] = gen_enable, pipe[k] = gen_enable delayed k

   assign cfg_ready  = (state == IDLE);
   assign busy       = (state != IDLE);
   assign gen_enable = pipe[0];
   assign byte_valid = pipe[DP_LAT];
   assign pre_last   = {gen_n, 2'b00} - PRE_W'(1);

   // Bytes still to emerge after the one currently presented.
   always_comb begin
      pend = 1'b0;
      for (int unsigned k = 0; k < DP_LAT; k++) pend = pend | pipe[k];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_d;
   end

   always_comb begin
      state_d   = state;
      pre_cnt_d = '0;
      pay_cnt_d = '0;
      gap_cnt_d = '0;
      abort_d   = abort_q;
      en_d      = 1'b0;
      take      = 1'b0;
      err_d     = 1'b0;
      done_d    = 1'b0;
      if (abort && (state == LOAD || state == PRE || state == PAY)) begin
         abort_d = 1'b1;
         state_d = END_ST;
      end else begin
         case (state)
            IDLE: begin
               if (cfg_valid) begin
                  if (cfg_len == '0) begin
                     err_d = 1'b1;
                  end else begin
                     take    = 1'b1;
                     abort_d = 1'b0;
                     state_d = LOAD;
                  end
               end
            end
            LOAD: begin
               en_d    = 1'b1;
               state_d = (gen_n != 8'd0) ? PRE : PAY;
            end
            PRE: begin
               en_d = 1'b1;
               if (pre_cnt == pre_last) state_d = PAY;
               else                     pre_cnt_d = pre_cnt + PRE_W'(1);
            end
            PAY: begin
               if (pay_cnt == len_q - LEN_W'(1)) begin
                  state_d = END_ST;
               end else begin
                  en_d      = 1'b1;
                  pay_cnt_d = pay_cnt + LEN_W'(1);
               end
            end
            DRAIN: begin
               if (!pend) state_d = GAP;
            end
            GAP: begin
               if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  gap_cnt_d = gap_cnt + GAP_W'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Frame markers are produced one cycle ahead so they land registered on the byte.
   generate
      if (DP_LAT == 0) begin : g_lat0
         // Only the natural end is predictable here; an aborted frame has no frame_end.
         assign fs_d = en_d & ~pipe[0];
         assign fe_d = en_d && (state_d == PAY) && (pay_cnt_d == len_q - LEN_W'(1));
      end else if (DP_LAT == 1) begin : g_lat1
         assign fs_d = pipe[0] & ~pipe[1];
         assign fe_d = pipe[0] & ~en_d;
      end else begin : g_latn
         assign fs_d = pipe[DP_LAT-1] & ~pipe[DP_LAT];
         assign fe_d = pipe[DP_LAT-1] & ~pipe[DP_LAT-2];
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre_cnt     <= '0;
         pay_cnt     <= '0;
         gap_cnt     <= '0;
         len_q       <= '0;
         abort_q     <= 1'b0;
         pipe        <= '0;
         gen_bytes   <= '0;
         gen_n       <= '0;
         gen_rst     <= 1'b0;
         frame_start <= 1'b0;
         frame_end   <= 1'b0;
         done        <= 1'b0;
         aborted     <= 1'b0;
         err         <= 1'b0;
      end else begin
         pre_cnt     <= pre_cnt_d;
         pay_cnt     <= pay_cnt_d;
         gap_cnt     <= gap_cnt_d;
         abort_q     <= abort_d;
         pipe[0]     <= en_d;
         for (int unsigned k = 1; k <= DP_LAT; k++) pipe[k] <= pipe[k-1];
         gen_rst     <= take;
         frame_start <= fs_d;
         frame_end   <= fe_d;
         done        <= done_d;
         aborted     <= done_d & abort_q;
         err         <= err_d;
         if (take) begin
            gen_bytes <= cfg_pattern;
            gen_n     <= cfg_n;
            len_q     <= cfg_len;
         end
      end
   end

endmodule
